vx_rr_stream_select: RTL and testbench
======================================

Name: vx_rr_stream_select

Overview:
- Round-robin arbitrated N:1 stream selector with valid/ready handshake on every input and on the output.
- Picks one requesting input per cycle, steers its payload through a combinational N:1 data mux, and registers the result in a single output stage.
- Sits upstream of the LSU/cache request crossbars; also exports the registered select index so downstream demux/response-routing logic can tag the transfer.

Parameters:
- DATAW, 32, payload width in bits.
- N, 4, number of input streams (>=1).
- LN, $clog2(N) (1 when N==1), width of select index.

Ports:
- clk  in  1  clock.
- resetn  in  1  asynchronous active-low reset.
- valid_in  in  N  per-input request valid.
- data_in  in  N*DATAW  per-input payload, packed [N-1:0][DATAW-1:0].
- last_in  in  N  per-input end-of-packet flag; used only with VX_RR_SELECT_LOCK_EN, ignored otherwise.
- ready_in  out  N  per-input accept.
- valid_out  out  1  output stage valid.
- data_out  out  DATAW  registered selected payload.
- sel_out  out  LN  registered index of the input that produced data_out.
- ready_out  in  1  downstream accept.

Behaviour:
- Clock and reset are fixed: one clock (clk); reset is asynchronous and active-low (resetn).
- Reset (async assert, sync release): valid_out=0, data_out=0, sel_out=0, rr pointer=0 (input 0 highest priority), lock state=UNLOCKED.
- Stage enable: en = ~valid_out | ready_out.
- Grant selection:
  - Combinational one-hot grant over valid_in.
  - Priority order is ptr, ptr+1, ..., N-1, 0, ..., ptr-1 (mod N).
- ready_in[i] = grant[i] & en. No input sees ready without being granted. ready_in never depends on valid_in[i] of the same index beyond arbitration.
- Transfer in: fire = |(valid_in & ready_in). On fire:
  - data_out <= data_in[gidx]; sel_out <= gidx; valid_out <= 1.
  - ptr <= (gidx==N-1) ? 0 : gidx+1.
- Transfer out: valid_out & ready_out with no fire -> valid_out <= 0. data_out and sel_out hold their values.
- Simultaneous out-transfer and in-fire in the same cycle -> new beat loaded, valid_out stays 1. This gives full throughput of one beat per cycle.
- Latency: one cycle from input handshake to valid_out.
- Stall: valid_out & ~ready_out -> all ready_in=0, ptr frozen, output held stable.
- No valid_in asserted -> no grant, ptr unchanged.
- N==1:
  - grant = valid_in, sel_out constant 0, ptr logic removed.
  - Behaves as a one-entry pipeline register.
- Reset mid-operation: a beat in the output stage is dropped and the lock is cleared.

Optional Feature:
- Macro: VX_RR_SELECT_LOCK_EN (packet lock).
- With the macro:
  - Two-state FSM: UNLOCKED / LOCKED(idx).
  - UNLOCKED: a fire with last_in[gidx]=0 -> LOCKED(gidx). The pointer does not advance.
  - LOCKED: grant is forced to idx. It is asserted only when valid_in[idx] is high; other inputs get ready_in=0.
  - LOCKED: a fire with last_in[idx]=1 -> UNLOCKED, ptr <= idx+1.
  - A single-beat packet (last=1 on its first beat) never locks.
- Without the macro: last_in is unused and arbitration is per beat.

Decomposition:
- Package vx_stream_pkg: lock-state enum (UNLOCKED, LOCKED), helper function for next rr pointer (mod-N increment).
- One sub-module, vx_rr_grant: parameter N; inputs req[N], ptr[LN]; outputs one-hot grant[N], gidx[LN], any.
- Top level: output register, lock FSM, and an inline data mux indexed by gidx.

Test Plan:
- Reset: hold resetn=0 with all valid_in=1 -> valid_out=0, sel_out=0, ready_in=0000. Release -> first beat out from input 0.
- Fairness: N=4, all valid continuously, ready_out=1 -> sel_out sequence 0,1,2,3,0,... one beat per cycle, data_out matches the source of each beat.
- Backpressure: ready_out=0 for 5 cycles with valid_out=1 -> data_out/sel_out stable, ready_in=0000, ptr unchanged. Resume -> next grant follows the prior winner.
- Sparse requests: only inputs 1 and 3 valid, ptr=2 -> grant 3 then 1. Output sequence sel=3, sel=1.
- Lock (VX_RR_SELECT_LOCK_EN): input 2 sends 3 beats (last=0,0,1) while inputs 0/1 are valid -> sel_out=2,2,2 contiguously, then sel=3 or 0 per pointer. Without the macro, the same stimulus interleaves.
- Async reset mid-stream: drop resetn while valid_out=1 -> valid_out goes to 0 immediately without a clock, and the lock clears.

Source files
------------

// File: rtl/vx_stream_pkg.sv
// Shared types and helpers for the round-robin stream selector.
package vx_stream_pkg;

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } lock_state_e;

    // Round-robin successor of idx among n inputs (wraps n-1 back to 0).
    function automatic int rr_next(input int idx, input int n);
        return (idx >= n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/vx_rr_stream_select_if.sv
// Bundle of the N input streams, the single output stream and debug taps of vx_rr_stream_select.
interface vx_rr_stream_select_if #(
    parameter int N     = 4,
    parameter int DATAW = 32,
    parameter int LN    = (N > 1) ? $clog2(N) : 1
);
    import vx_stream_pkg::*;

    // Handshake: a beat moves on a cycle where valid and ready are both high at the
    // rising clock edge; valid never waits on ready, payload is held while valid and not ready.
    logic [N-1:0]            valid_in;
    logic [N-1:0][DATAW-1:0] data_in;
    logic [N-1:0]            last_in;
    logic [N-1:0]            ready_in;
    logic                    valid_out;
    logic [DATAW-1:0]        data_out;
    logic [LN-1:0]           sel_out;
    logic                    ready_out;
    logic [LN-1:0]           dbg_ptr;
    lock_state_e             dbg_lock_state;

    modport slave (
        input  valid_in, data_in, last_in, ready_out,
        output ready_in, valid_out, data_out, sel_out, dbg_ptr, dbg_lock_state
    );

    modport master (
        output valid_in, data_in, last_in, ready_out,
        input  ready_in, valid_out, data_out, sel_out, dbg_ptr, dbg_lock_state
    );

endinterface

// File: rtl/vx_rr_grant.sv
// Combinational round-robin arbiter: first requester at or after ptr (mod N) wins a one-hot grant.
module vx_rr_grant #(
    parameter int  N  = 4,
    localparam int LN = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [LN-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [LN-1:0] gidx,
    output logic          any
);

    assign any = |req;

    if (N == 1) begin : g_single
        logic unused_ptr;
        assign unused_ptr = ^ptr;
        assign grant      = req;
        assign gidx       = '0;
    end else begin : g_rr
        logic [LN:0]   pos;
        logic [LN-1:0] idx;
        logic          found;

        // One extra bit on pos keeps ptr+k from wrapping before the mod-N fold.
        always_comb begin
            grant = '0;
            gidx  = '0;
            found = 1'b0;
            pos   = '0;
            idx   = '0;
            for (int k = 0; k < N; k++) begin
                pos = {1'b0, ptr} + (LN+1)'(k);
                if (pos >= (LN+1)'(N)) pos = pos - (LN+1)'(N);
                idx = pos[LN-1:0];
                if (!found && req[idx]) begin
                    found      = 1'b1;
                    grant[idx] = 1'b1;
                    gidx       = idx;
                end
            end
        end
    end

endmodule

// File: rtl/vx_rr_stream_select.sv
// Round-robin N:1 stream selector with one registered output stage and exported select index.
// Define VX_RR_SELECT_LOCK_EN to keep the grant on one input until the beat carrying last_in.
module vx_rr_stream_select
    import vx_stream_pkg::*;
#(
    parameter int DATAW = 32,
    parameter int N     = 4,
    parameter int LN    = (N > 1) ? $clog2(N) : 1
) (
    input logic                  clk,
    input logic                  resetn,
    vx_rr_stream_select_if.slave s
);

    logic             valid_q, valid_d;
    logic [DATAW-1:0] data_q, data_d;
    logic [LN-1:0]    sel_q, sel_d;
    logic [LN-1:0]    ptr_q, ptr_d;
    logic [N-1:0]     rr_grant, grant, ready;
    logic [LN-1:0]    rr_gidx, gidx;
    logic             unused_any;
    logic             en, fire, advance;

    vx_rr_grant #(.N(N)) u_grant (
        .req   (s.valid_in),
        .ptr   (ptr_q),
        .grant (rr_grant),
        .gidx  (rr_gidx),
        .any   (unused_any)
    );

    // resetn gates en so no input is offered ready while the stage is held in reset.
    assign en    = resetn & (~valid_q | s.ready_out);
    assign ready = grant & {N{en}};
    assign fire  = |(s.valid_in & ready);

`ifdef VX_RR_SELECT_LOCK_EN
    lock_state_e   lock_state_q, lock_state_d;
    logic [LN-1:0] lock_idx_q, lock_idx_d;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lock_state_q <= UNLOCKED;
            lock_idx_q   <= '0;
        end else begin
            lock_state_q <= lock_state_d;
            lock_idx_q   <= lock_idx_d;
        end
    end

    always_comb begin
        lock_state_d = lock_state_q;
        lock_idx_d   = lock_idx_q;
        case (lock_state_q)
            UNLOCKED: if (fire && !s.last_in[gidx]) begin
                lock_state_d = LOCKED;
                lock_idx_d   = gidx;
            end
            LOCKED:   if (fire && s.last_in[lock_idx_q]) lock_state_d = UNLOCKED;
            default:  lock_state_d = UNLOCKED;
        endcase
    end

    // While locked only the owning input may move, and only when it is valid.
    always_comb begin
        grant = rr_grant;
        gidx  = rr_gidx;
        if (lock_state_q == LOCKED) begin
            grant             = '0;
            grant[lock_idx_q] = s.valid_in[lock_idx_q];
            gidx              = lock_idx_q;
        end
    end

    assign advance          = fire & s.last_in[gidx];
    assign s.dbg_lock_state = lock_state_q;
`else
    logic unused_last;
    assign unused_last      = ^s.last_in;
    assign grant            = rr_grant;
    assign gidx             = rr_gidx;
    assign advance          = fire;
    assign s.dbg_lock_state = UNLOCKED;
`endif

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        if (fire) begin
            valid_d = 1'b1;
            data_d  = s.data_in[gidx];
            sel_d   = gidx;
        end else if (s.ready_out) begin
            valid_d = 1'b0;
        end
        if (advance && N > 1) ptr_d = LN'(rr_next(int'(gidx), N));
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            sel_q   <= '0;
            ptr_q   <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
        end
    end

    assign s.ready_in  = ready;
    assign s.valid_out = valid_q;
    assign s.data_out  = data_q;
    assign s.sel_out   = sel_q;
    assign s.dbg_ptr   = ptr_q;

endmodule

// File: tb/tb_vx_rr_stream_select.sv
// Bench for vx_rr_stream_select: directed phases plus random traffic against a beat-level model.
module tb_vx_rr_stream_select;
    import vx_stream_pkg::*;

    localparam int N     = 4;
    localparam int DATAW = 32;
    localparam int LN    = 2;

    logic clk    = 1'b0;
    logic resetn = 1'b0;
    int   total  = 0;
    int   bad    = 0;
    bit   chk_on = 1'b0;

    vx_rr_stream_select_if #(.N(N), .DATAW(DATAW)) sif ();

    vx_rr_stream_select #(.DATAW(DATAW), .N(N)) dut (
        .clk    (clk),
        .resetn (resetn),
        .s      (sif)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic             m_valid  = 1'b0;
    logic [DATAW-1:0] m_data   = '0;
    int               m_sel    = 0;
    int               m_ptr    = 0;
    bit               m_locked = 1'b0;
    int               m_lidx   = 0;
    logic [DATAW-1:0] exp_q[$];

    function automatic int pick(input logic [N-1:0] v);
        if (m_locked) return v[m_lidx] ? m_lidx : -1;
        for (int k = 0; k < N; k++)
            if (v[(m_ptr + k) % N]) return (m_ptr + k) % N;
        return -1;
    endfunction

    function automatic logic [N-1:0] exp_ready();
        int g;
        logic [N-1:0] r;
        g = pick(sif.valid_in);
        r = '0;
        if (resetn && (!m_valid || sif.ready_out) && g >= 0) r[g] = 1'b1;
        return r;
    endfunction

    always @(posedge clk or negedge resetn) begin : model
        int g;
        bit fire;
        if (!resetn) begin
            m_valid  <= 1'b0;
            m_data   <= '0;
            m_sel    <= 0;
            m_ptr    <= 0;
            m_locked <= 1'b0;
            m_lidx   <= 0;
            exp_q.delete();
        end else begin
            g    = pick(sif.valid_in);
            fire = (g >= 0) && (!m_valid || sif.ready_out);
            if (fire) begin
                m_valid <= 1'b1;
                m_data  <= sif.data_in[g];
                m_sel   <= g;
                exp_q.push_back(sif.data_in[g]);
`ifdef VX_RR_SELECT_LOCK_EN
                if (!sif.last_in[g]) begin
                    m_locked <= 1'b1;
                    m_lidx   <= g;
                end else begin
                    m_locked <= 1'b0;
                    m_ptr    <= (g + 1) % N;
                end
`else
                m_ptr <= (g + 1) % N;
`endif
            end else if (sif.ready_out) begin
                m_valid <= 1'b0;
            end
        end
    end

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            chk("ready_in", sif.ready_in, exp_ready());
            chk("valid_out", sif.valid_out, m_valid);
            chk("sel_out", sif.sel_out, m_sel);
            chk("data_out", sif.data_out, m_data);
            chk("ptr", sif.dbg_ptr, m_ptr);
            chk("locked", sif.dbg_lock_state == LOCKED, m_locked);
            if (sif.valid_out && sif.ready_out) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL sb_underflow: got beat %0h expected none", sif.data_out);
                end else begin
                    chk("sb_data", sif.data_out, exp_q.pop_front());
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_data();
        for (int i = 0; i < N; i++) sif.data_in[i] = $urandom();
    endtask

    initial begin
        logic [DATAW-1:0] d, hd;
        logic [LN-1:0]    hs;
        int               b, nrec;
        bit               fired, hs2;
        int               lk_sel[4];
        int               exp_lk[4];

        sif.valid_in  = '1;
        sif.last_in   = '1;
        sif.ready_out = 1'b1;
        rand_data();

        // reset held with every input requesting
        tick();
        chk_on = 1'b1;
        repeat (2) tick();
        @(negedge clk);
        chk("rst_valid", sif.valid_out, 0);
        chk("rst_sel", sif.sel_out, 0);
        chk("rst_ready", sif.ready_in, 0);
        tick();
        resetn = 1'b1;

        // fairness: all valid, no backpressure, one beat per cycle from 0,1,2,3,...
        for (int k = 0; k < 8; k++) begin
            d = sif.data_in[k % N];
            tick();
            rand_data();
            if (k == 7) sif.ready_out = 1'b0;
            @(negedge clk);
            chk("fair_sel", sif.sel_out, k % N);
            chk("fair_data", sif.data_out, d);
        end

        // backpressure: output held, no input ready, pointer frozen
        hs = sif.sel_out;
        hd = sif.data_out;
        for (int j = 0; j < 5; j++) begin
            tick();
            rand_data();
            @(negedge clk);
            chk("stall_sel", sif.sel_out, hs);
            chk("stall_data", sif.data_out, hd);
            chk("stall_ready", sif.ready_in, 0);
            chk("stall_ptr", sif.dbg_ptr, 0);
        end
        tick();
        sif.ready_out = 1'b1;
        d = sif.data_in[0];
        tick();
        @(negedge clk);
        chk("resume_sel", sif.sel_out, 0);
        chk("resume_data", sif.data_out, d);

        // sparse: input 1 wins (ptr -> 2), then only 1 and 3 valid -> 3 then 1
        tick();
        sif.valid_in = 4'b1010;
        @(negedge clk);
        chk("sparse_sel0", sif.sel_out, 1);
        chk("sparse_ptr", sif.dbg_ptr, 2);
        tick();
        @(negedge clk);
        chk("sparse_sel1", sif.sel_out, 3);
        tick();
        sif.valid_in = 4'b0111;
        sif.last_in  = 4'b1011;
        @(negedge clk);
        chk("sparse_sel2", sif.sel_out, 1);

        // packet on input 2 (last=0,0,1) competing with inputs 0/1
        b     = 0;
        nrec  = 0;
        fired = 1'b0;
        for (int c = 0; c < 40 && !(b == 3 && nrec >= 4); c++) begin
            fired = |(sif.valid_in & sif.ready_in);
            hs2   = sif.valid_in[2] & sif.ready_in[2];
            tick();
            if (hs2) b++;
            sif.valid_in[2] = (b < 3);
            sif.last_in[2]  = (b == 2);
            rand_data();
            @(negedge clk);
            if (fired && nrec < 4) begin
                lk_sel[nrec] = int'(sif.sel_out);
                nrec++;
            end
        end
        if (!(b == 3 && nrec >= 4)) begin
            total++;
            bad++;
            $display("FAIL lock_timeout: beats=%0d recorded=%0d expected 3 and 4", b, nrec);
        end
`ifdef VX_RR_SELECT_LOCK_EN
        exp_lk = '{2, 2, 2, 0};
`else
        exp_lk = '{2, 0, 1, 2};
`endif
        for (int i = 0; i < 4; i++) chk("pkt_sel", lk_sel[i], exp_lk[i]);

        // random traffic
        for (int c = 0; c < 400; c++) begin
            tick();
            sif.valid_in  = N'($urandom_range(0, 15));
            for (int i = 0; i < N; i++) sif.last_in[i] = ($urandom_range(0, 2) == 0);
            sif.ready_out = ($urandom_range(0, 3) != 0);
            rand_data();
        end

        // async reset with a beat in the output stage (and a packet lock held)
        tick();
        sif.valid_in  = '1;
        sif.last_in   = '0;
        sif.ready_out = 1'b1;
        tick();
        sif.ready_out = 1'b0;
        @(negedge clk);
        chk("pre_rst_valid", sif.valid_out, 1);
`ifdef VX_RR_SELECT_LOCK_EN
        chk("pre_rst_locked", sif.dbg_lock_state == LOCKED, 1);
`endif
        #2;
        resetn = 1'b0;
        #1;
        chk("async_valid", sif.valid_out, 0);
        chk("async_sel", sif.sel_out, 0);
        chk("async_ready", sif.ready_in, 0);
        chk("async_unlocked", sif.dbg_lock_state == LOCKED, 0);
        repeat (2) tick();
        resetn        = 1'b1;
        sif.last_in   = '1;
        sif.ready_out = 1'b1;
        d             = sif.data_in[0];
        tick();
        @(negedge clk);
        chk("post_rst_sel", sif.sel_out, 0);
        chk("post_rst_data", sif.data_out, d);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
